avalon_mem_responder: RTL and testbench

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

---
 rtl/avalon_mem_responder.sv | 121 ++++++++++++
 tb/tb_avalon_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory slave with a fixed read latency and a cap on in-flight reads.
// Define MEM_STALL_INSERT_EN to hold waitrequest high for the first cycle of every new command.
module avalon_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned RD_LATENCY      = 3,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;

  logic [31:0]           ram [DEPTH_WORDS];
  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           data_q [RD_LATENCY];
  logic [CW-1:0]         outstanding_q;
  logic                  err_q;

  logic          cmd_c, acc_c, acc_wr_c, acc_rd_c, in_range_c, retire_c, cap_stall_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   rd_word_c;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^slave_address[1:0];

  assign idx_c       = slave_address[AW+1:2];
  assign in_range_c  = slave_address[31:2] < 30'(DEPTH_WORDS);
  assign rd_word_c   = in_range_c ? ram[idx_c] : OOR_DATA;
  assign retire_c    = vld_q[RD_LATENCY-1];
  assign cap_stall_c = (outstanding_q == CW'(MAX_OUTSTANDING)) && !retire_c;
  assign cmd_c       = slave_read | slave_write;
  assign acc_c       = cmd_c && !slave_waitrequest && rst_n;
  assign acc_wr_c    = acc_c && slave_write;
  // A simultaneous read+write is treated as a write; the read half is dropped.
  assign acc_rd_c    = acc_c && slave_read && !slave_write;

`ifdef MEM_STALL_INSERT_EN
  typedef enum logic {ST_IDLE, ST_READY} stall_state_t;
  stall_state_t state_q, state_d;
  logic         stall_first_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // First cycle of a new command always stalls; accepting it re-arms the stall.
  always_comb begin
    state_d       = state_q;
    stall_first_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_c) begin
          stall_first_c = 1'b1;
          state_d       = ST_READY;
        end
      end
      ST_READY: begin
        if (!cmd_c || !cap_stall_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign slave_waitrequest = stall_first_c | cap_stall_c;
`else
  assign slave_waitrequest = cap_stall_c;
`endif

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (acc_wr_c && in_range_c) ram[idx_c] <= slave_writedata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q[0]      <= 1'b0;
      data_q[0]     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      vld_q[0] <= acc_rd_c;
      if (acc_rd_c) data_q[0] <= rd_word_c;
      case ({acc_rd_c, retire_c})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (acc_c && slave_read && slave_write) err_q <= 1'b1;
    end
  end

  // Data stages only load on a valid so the last stage holds the previous response.
  for (genvar g = 1; g < RD_LATENCY; g++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[g]  <= 1'b0;
        data_q[g] <= '0;
      end else begin
        vld_q[g] <= vld_q[g-1];
        if (vld_q[g-1]) data_q[g] <= data_q[g-1];
      end
    end
  end

  assign slave_readdatavalid = vld_q[RD_LATENCY-1];
  assign slave_readdata      = data_q[RD_LATENCY-1];
  assign err                 = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: directed vector table, reset corner cases and
// randomized traffic checked against a queue-based transaction model.
module tb_avalon_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] slave_address, slave_writedata;
  logic        slave_read, slave_write;
  logic        slave_waitrequest, slave_readdatavalid, err;
  logic [31:0] slave_readdata;

  always #5 clk = ~clk;

  avalon_mem_responder #(
    .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid), .err(err)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model: a queue of promised responses (due cycle + data) and an array for the RAM.
  typedef struct { int unsigned due; logic [31:0] data; } resp_t;
  resp_t       rq[$];
  logic [31:0] mem [DEPTH];
  bit          ret_now;
  bit          exp_err;
  bit          prev_pending;
  logic [31:0] last_rd;
  bit          tbl_mode;
  logic [31:0] tbl_q[$];

  typedef struct {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] data; logic [31:0] exp_rdata; int exp_waits;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    tbl_q.delete();
    ret_now = 0; exp_err = 0; prev_pending = 0; last_rd = '0;
  endtask

  task automatic model_accept(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [29:0] idx;
    bit inr;
    idx = a[31:2];
    inr = idx < 30'(DEPTH);
    if (wr) begin
      if (rd) exp_err = 1;
      if (inr) mem[idx[9:0]] = d;
    end else begin
      rq.push_back('{due: cyc + LAT, data: (inr ? mem[idx[9:0]] : 32'hDEADBEEF)});
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    chk("readdatavalid", 32'(slave_readdatavalid), 32'(exp_v));
    ret_now = exp_v;
    if (exp_v) begin
      last_rd = rq[0].data;
      void'(rq.pop_front());
      if (tbl_mode && tbl_q.size() > 0) chk("table_rdata", slave_readdata, tbl_q.pop_front());
    end
    chk("readdata", slave_readdata, last_rd);
    chk("err", 32'(err), 32'(exp_err));
  endtask

  // One clock cycle: drive at negedge, check waitrequest, then check outputs next negedge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output bit acc);
    bit cmd, exp_wait;
    int unsigned outst;
    slave_read = rd; slave_write = wr; slave_address = a; slave_writedata = d;
    #1;
    cmd      = rd | wr;
    outst    = rq.size() + 32'(ret_now);
    exp_wait = (outst == MAXO) && !ret_now;
`ifdef MEM_STALL_INSERT_EN
    if (cmd && !prev_pending) exp_wait = 1;
`endif
    chk("waitrequest", 32'(slave_waitrequest), 32'(exp_wait));
    acc          = cmd && !exp_wait;
    prev_pending = cmd && !acc;
    if (acc) model_accept(rd, wr, a, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int waits);
    bit acc;
    waits = 0;
    step(rd, wr, a, d, acc);
    while (!acc && waits < 20) begin
      waits++;
      step(rd, wr, a, d, acc);
    end
    if (!acc) chk("issue_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slave_read = 1'b0; slave_write = 1'b0; slave_address = '0; slave_writedata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    chk("rst_readdatavalid", 32'(slave_readdatavalid), 32'd0);
    chk("rst_readdata", slave_readdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #1;
    chk("rst_waitrequest", 32'(slave_waitrequest), 32'd0);
  endtask

  initial begin
    int w;
    bit acc;
    logic cur_rd, cur_wr;
    logic [31:0] cur_a, cur_d;
    bit have_cmd;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'd7,            32'h0,            -1};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_000C, 32'd102236,       32'h0,            -1};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,            32'd102236,       -1};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'd81265,        32'h0,            -1};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0014, 32'(-163185),     32'h0,            -1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,            32'd102236,        0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,            32'd81265,         0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,            32'(-163185),      1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,            32'hDEADBEEF,      0};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_1000, 32'd12345,        32'h0,             1};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,            32'd7,            -1};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_0020, 32'd65536,        32'h0,            -1};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,            32'd65536,        -1};

    rst_n = 1'b0;
    slave_read = 1'b0; slave_write = 1'b0; slave_address = '0; slave_writedata = '0;
    @(negedge clk);
    do_reset();

    // Directed vectors.
    tbl_mode = 1;
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rd && !tbl[i].wr) tbl_q.push_back(tbl[i].exp_rdata);
      issue(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, w);
`ifndef MEM_STALL_INSERT_EN
      if (tbl[i].exp_waits >= 0) chk($sformatf("table_waits[%0d]", i), 32'(w), 32'(tbl[i].exp_waits));
`endif
      if (i == 10) chk("err_before_collision", 32'(err), 32'd0);
    end
    idle(LAT + 3);
    chk("err_after_collision", 32'(err), 32'd1);
    chk("table_responses_left", 32'(tbl_q.size()), 32'd0);
    tbl_mode = 0;

    // Read in flight when reset hits: no strobe afterwards, full capacity available again.
    do_reset();
    issue(1'b1, 1'b0, 32'h0000_000C, 32'h0, w);
    do_reset();
    idle(LAT + 3);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, w);
    issue(1'b1, 1'b0, 32'h0000_0014, 32'h0, w);
`ifndef MEM_STALL_INSERT_EN
    chk("post_reset_second_read_waits", 32'(w), 32'd0);
`endif
    idle(LAT + 2);
    chk("ram_kept_after_reset", slave_readdata, 32'(-163185));

`ifdef MEM_STALL_INSERT_EN
    issue(1'b1, 1'b0, 32'h0000_000C, 32'h0, w);
    chk("stall_insert_waits", 32'(w), 32'd1);
    idle(LAT + 2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, w);
    issue(1'b0, 1'b1, 32'(1023 * 4), $urandom, w);
    have_cmd = 0;
    cur_rd = 0; cur_wr = 0; cur_a = '0; cur_d = '0;
    for (int it = 0; it < 1500; it++) begin
      int r, s;
      if (it == 750) begin
        do_reset();
        have_cmd = 0;
      end
      if (!have_cmd) begin
        r = int'($urandom_range(0, 99));
        cur_rd = (r < 35) || (r >= 55 && r < 58);
        cur_wr = (r >= 35 && r < 58);
        s = int'($urandom_range(0, 19));
        if (s < 16)      cur_a = 32'(s * 4);
        else if (s < 18) cur_a = 32'(1023 * 4);
        else             cur_a = 32'((1024 + $urandom_range(0, 7)) * 4);
        cur_a = cur_a + 32'($urandom_range(0, 3));
        cur_d = $urandom;
      end
      step(cur_rd, cur_wr, cur_a, cur_d, acc);
      have_cmd = (cur_rd | cur_wr) && !acc;
    end
    idle(LAT + 3);
    chk("random_responses_left", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
